// File: rtl/pic_instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its program ROM,
// file register array and combinational opcode ALU.
interface pic_instr_sequencer_if #(
    parameter int PC_W = 8,
    parameter int FA_W = 5
);
    logic [PC_W-1:0] prog_addr;
    logic [11:0]     prog_data;
    logic [FA_W-1:0] fr_addr;
    logic [7:0]      fr_rdata;
    logic [7:0]      fr_wdata;
    logic            fr_we;
    logic [11:0]     alu_opcode;
    logic [7:0]      alu_f;
    logic [7:0]      alu_w;
    logic [7:0]      alu_r;

    modport master (
        output prog_addr, fr_addr, fr_wdata, fr_we, alu_opcode, alu_f, alu_w,
        input  prog_data, fr_rdata, alu_r
    );

    modport slave (
        input  prog_addr, fr_addr, fr_wdata, fr_we, alu_opcode, alu_f, alu_w,
        output prog_data, fr_rdata, alu_r
    );
endinterface

// File: rtl/pic_instr_sequencer.sv
// Q-cycle instruction sequencer for a 12-bit-opcode PIC10F200-class core:
// fetch, operand latch, writeback, 2-level call stack and skip/branch flush.
module pic_instr_sequencer #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b1}},
    parameter int              FA_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    pic_instr_sequencer_if.master bus,
    output logic [7:0]            w_out,
    output logic [1:0]            phase
);
    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

    phase_t          q;
    logic [PC_W-1:0] pc;
    logic [11:0]     ir;
    logic [7:0]      w;
    logic [7:0]      f_lat;
    logic [7:0]      res_lat;
    logic            flush;
    logic [PC_W-1:0] stack [2];
    logic [1:0]      sp;
    logic            fr_we_r;
    logic [7:0]      fr_wdata_r;

    logic            is_byte, is_misc, is_movwf, is_fsz, is_bitop, is_btst;
    logic            is_retlw, is_call, is_goto, is_branch;
    logic            dest_f, dest_w, skip_cond;
    logic [PC_W-1:0] pop_val;

    always_comb begin
        is_byte   = (ir[11:10] == 2'b00);
        is_misc   = (ir[11:5] == 7'd0);
        is_movwf  = (ir[11:5] == 7'b0000001);
        is_fsz    = (ir[11:9] == 3'b001) && (ir[7:6] == 2'b11);
        is_bitop  = (ir[11:10] == 2'b01);
        is_btst   = is_bitop && ir[9];
        is_retlw  = (ir[11:8] == 4'b1000);
        is_call   = (ir[11:8] == 4'b1001);
        is_goto   = (ir[11:9] == 3'b101);
        is_branch = is_retlw || is_call || is_goto;
        dest_f    = (is_byte && !is_misc && ir[5]) || (is_bitop && !ir[9]);
        dest_w    = (is_byte && !is_misc && !ir[5]) || (ir[11:10] == 2'b11);
        // BTFSC skips on a clear bit, BTFSS on a set bit: compare against IR[8]
        skip_cond = (is_fsz && (bus.alu_r == 8'd0)) ||
                    (is_btst && (f_lat[ir[7:5]] == ir[8]));
        pop_val   = (sp == 2'd2) ? stack[1] : stack[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= Q1;
            pc         <= RESET_VEC;
            ir         <= 12'h000;
            w          <= 8'h00;
            f_lat      <= 8'h00;
            res_lat    <= 8'h00;
            flush      <= 1'b0;
            stack[0]   <= '0;
            stack[1]   <= '0;
            sp         <= 2'd0;
            fr_we_r    <= 1'b0;
            fr_wdata_r <= 8'h00;
        end else begin
            case (q)
                Q1: if (run) q <= Q2;
                Q2: begin
                    f_lat <= bus.fr_rdata;
                    q     <= Q3;
                end
                Q3: begin
                    res_lat    <= bus.alu_r;
                    fr_we_r    <= dest_f;
                    fr_wdata_r <= is_movwf ? w : bus.alu_r;
                    flush      <= skip_cond || is_branch;
                    q          <= Q4;
                end
                Q4: begin
                    fr_we_r <= 1'b0;
                    flush   <= 1'b0;
                    q       <= Q1;
                    ir      <= flush ? 12'h000 : bus.prog_data;
                    if (is_retlw)
                        w <= ir[7:0];
                    else if (dest_w)
                        w <= res_lat;
                    // A push onto a full stack drops the oldest return address
                    if (is_goto) begin
                        pc <= PC_W'(ir[8:0]);
                    end else if (is_call) begin
                        pc <= PC_W'(ir[7:0]);
                        if (sp == 2'd2) begin
                            stack[0] <= stack[1];
                            stack[1] <= pc;
                        end else begin
                            stack[sp[0]] <= pc;
                            sp           <= sp + 2'd1;
                        end
                    end else if (is_retlw) begin
                        pc <= pop_val;
                        if (sp != 2'd0) sp <= sp - 2'd1;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: q <= Q1;
            endcase
        end
    end

    assign bus.prog_addr  = pc;
    assign bus.fr_addr    = ir[FA_W-1:0];
    assign bus.fr_wdata   = fr_wdata_r;
    assign bus.fr_we      = fr_we_r;
    assign bus.alu_opcode = ir;
    assign bus.alu_f      = f_lat;
    assign bus.alu_w      = w;
    assign w_out          = w;
    assign phase          = q;
endmodule

// File: tb/tb_pic_instr_sequencer.sv
// Randomized bench for pic_instr_sequencer against an instruction-level
// reference model (whole instructions, queue-based call stack).
module tb_pic_instr_sequencer;
    localparam int PC_W = 8;
    localparam int FA_W = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] w_out;
    logic [1:0] phase;

    pic_instr_sequencer_if #(.PC_W(PC_W), .FA_W(FA_W)) bus ();

    pic_instr_sequencer #(.PC_W(PC_W), .RESET_VEC(8'hFF), .FA_W(FA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .bus   (bus),
        .w_out (w_out),
        .phase (phase)
    );

    always #5 clk = ~clk;

    logic [11:0] rom      [256];
    logic [7:0]  env_file [32];

    // Stand-in ALU: real semantics for the ops whose result drives skips
    function automatic logic [7:0] aluFn(input logic [11:0] op, input logic [7:0] f,
                                         input logic [7:0] w);
        logic [7:0] bitm;
        bitm = 8'd1 << op[7:5];
        if (op[11:9] == 3'b001 && op[7:6] == 2'b11) return op[8] ? f + 8'd1 : f - 8'd1;
        if (op[11:9] == 3'b010) return op[8] ? (f | bitm) : (f & ~bitm);
        if (op[11:8] == 4'hC) return op[7:0];
        return (f + op[7:0]) ^ w;
    endfunction

    assign bus.prog_data = rom[bus.prog_addr];
    assign bus.fr_rdata  = env_file[bus.fr_addr];
    assign bus.alu_r     = aluFn(bus.alu_opcode, bus.alu_f, bus.alu_w);

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m_pc;
    logic [11:0] m_ir;
    logic [7:0]  m_w;
    logic [7:0]  m_file [32];
    logic [7:0]  stk [$];
    logic [7:0]  m_last;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc   = 8'hFF;
        m_ir   = 12'h000;
        m_w    = 8'h00;
        m_last = 8'h00;
        stk.delete();
    endtask

    function automatic logic [11:0] randOp();
        logic [11:0] op;
        int k;
        op = 12'($urandom);
        k  = $urandom_range(0, 9);
        case (k)
            0: op = 12'h000;
            1: op = {7'b0000001, op[4:0]};
            2: op = {6'b001011, op[5:0]};
            3: op = {6'b001111, op[5:0]};
            4: begin
                op = {2'b00, op[9:0]};
                if (op[11:5] == 7'd0) op = 12'h000;
            end
            5: op = {3'b010, op[8:0]};
            6: op = {3'b011, op[8:0]};
            7: op = {4'b1000, op[7:0]};
            8: op = op[11] ? {4'b1001, op[7:0]} : {3'b101, op[8:0]};
            default: op = {2'b11, op[9:0]};
        endcase
        return op;
    endfunction

    function automatic logic [7:0] seedVal();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'hFF;
            3: return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic doReset();
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_phase", phase, 0);
        checkOutput("rst_pc", bus.prog_addr, 8'hFF);
        checkOutput("rst_ir", bus.alu_opcode, 12'h000);
        checkOutput("rst_w", w_out, 8'h00);
        checkOutput("rst_we", bus.fr_we, 0);
        rst = 1'b0;
        modelReset();
    endtask

    // One whole instruction: entered and left just after the edge into Q1
    task automatic applyStimulus();
        logic [7:0] f, res, fdata, wval, tgt;
        logic       wr_f, wr_w, skip, brch;

        checkOutput("q1_phase", phase, 0);
        checkOutput("ir", bus.alu_opcode, m_ir);
        checkOutput("pc", bus.prog_addr, m_pc);
        checkOutput("w", w_out, m_w);
        checkOutput("fr_addr", bus.fr_addr, m_ir[4:0]);
        checkOutput("we_q1", bus.fr_we, 0);
        while ($urandom_range(0, 4) == 0) begin
            run = 1'b0;
            @(posedge clk); #1;
            checkOutput("stall_phase", phase, 0);
            checkOutput("stall_pc", bus.prog_addr, m_pc);
            checkOutput("stall_ir", bus.alu_opcode, m_ir);
        end
        run = 1'b1;

        f     = m_file[m_ir[4:0]];
        res   = aluFn(m_ir, f, m_w);
        wr_f  = 1'b0;
        wr_w  = 1'b0;
        skip  = 1'b0;
        brch  = 1'b0;
        fdata = res;
        wval  = res;
        tgt   = m_pc + 8'd1;
        if (m_ir[11:10] == 2'b00) begin
            if (m_ir[11:5] == 7'b0000001) begin
                wr_f  = 1'b1;
                fdata = m_w;
            end else if (m_ir[11:5] != 7'd0) begin
                wr_f = m_ir[5];
                wr_w = !m_ir[5];
            end
            if (m_ir[11:6] == 6'b001011 || m_ir[11:6] == 6'b001111) skip = (res == 8'd0);
        end else if (m_ir[11:10] == 2'b01) begin
            if (!m_ir[9]) wr_f = 1'b1;
            else skip = (f[m_ir[7:5]] == m_ir[8]);
        end else if (m_ir[11:10] == 2'b10) begin
            brch = 1'b1;
            if (m_ir[9:8] == 2'b00) begin
                wr_w = 1'b1;
                wval = m_ir[7:0];
                if (stk.size() > 0) m_last = stk.pop_back();
                tgt = m_last;
            end else if (m_ir[9:8] == 2'b01) begin
                stk.push_back(m_pc);
                if (stk.size() > 2) void'(stk.pop_front());
                tgt = m_ir[7:0];
            end else begin
                tgt = m_ir[7:0];
            end
        end else begin
            wr_w = 1'b1;
        end

        @(posedge clk); #1;
        run = 1'($urandom_range(0, 1));
        checkOutput("q2_phase", phase, 1);
        checkOutput("we_q2", bus.fr_we, 0);
        @(posedge clk); #1;
        checkOutput("q3_phase", phase, 2);
        checkOutput("alu_f", bus.alu_f, f);
        checkOutput("we_q3", bus.fr_we, 0);
        @(posedge clk); #1;
        checkOutput("q4_phase", phase, 3);
        checkOutput("we_q4", bus.fr_we, wr_f);
        if (wr_f) begin
            checkOutput("wr_addr", bus.fr_addr, m_ir[4:0]);
            checkOutput("wr_data", bus.fr_wdata, fdata);
        end
        if (bus.fr_we) env_file[bus.fr_addr] = bus.fr_wdata;
        @(posedge clk); #1;

        if (wr_f) m_file[m_ir[4:0]] = fdata;
        if (wr_w) m_w = wval;
        m_ir = (skip || brch) ? 12'h000 : rom[m_pc];
        m_pc = tgt;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 32; i++) begin
            env_file[i] = seedVal();
            m_file[i]   = env_file[i];
        end
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;

        // Directed: MOVLW after reset, then three nested CALLs unwound by RETLWs
        rom[8'hFF] = 12'hC5A;
        rom[8'h00] = 12'h910;
        rom[8'h10] = 12'h920;
        rom[8'h20] = 12'h930;
        rom[8'h30] = 12'h801;
        rom[8'h21] = 12'h802;
        rom[8'h11] = 12'h803;
        doReset();
        repeat (2) applyStimulus();
        checkOutput("movlw_w", w_out, 8'h5A);
        checkOutput("movlw_pc", bus.prog_addr, 8'h01);
        repeat (11) applyStimulus();
        checkOutput("nest_pc", bus.prog_addr, 8'h11);
        checkOutput("nest_w", w_out, 8'h03);

        for (int i = 0; i < 256; i++) rom[i] = randOp();
        doReset();
        repeat (400) applyStimulus();

        // Reset landing in Q3 of an ADDWF f=7,d=1 must suppress the write
        rom[8'hFF] = 12'h1E7;
        doReset();
        applyStimulus();
        checkOutput("pre_ir", bus.alu_opcode, 12'h1E7);
        run = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_rst_phase", phase, 2);
        rst = 1'b1;
        #1;
        checkOutput("arst_phase", phase, 0);
        checkOutput("arst_pc", bus.prog_addr, 8'hFF);
        checkOutput("arst_ir", bus.alu_opcode, 12'h000);
        checkOutput("arst_we", bus.fr_we, 0);
        checkOutput("arst_w", w_out, 8'h00);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("rst_hold_we", bus.fr_we, 0);
        end
        rst = 1'b0;
        modelReset();
        repeat (20) applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
